chicken_turn_ctrl: RTL and testbench

Game-state register block for the two-chicken race track (24 tiles, positions 0..23). Holds both chickens' positions, whose turn it is and each player's overtake score. It drives the current/opponent position pair into the downstream next-position stage and registers the returned `pos_data` when the card-match logic reports a correct guess. It also passes the turn on a miss and declares a winner after `WIN_TAILS` overtakes.

---
 rtl/chicken_turn_ctrl.sv | 139 +++++++++++++
 tb/tb_chicken_turn_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chicken_turn_ctrl.sv
// Game-state registers for the two-chicken race: positions, turn, overtake scores
// and the IDLE/PLAY/WIN flow around the external next-position stage.
module chicken_turn_ctrl #(
   parameter logic [4:0]  P1_START  = 5'd0,
   parameter logic [4:0]  P2_START  = 5'd12,
   parameter int unsigned WIN_TAILS = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       match,
   input  logic       miss,
   input  logic [4:0] pos_data,
   output logic [4:0] out1,
   output logic [4:0] out2,
   output logic [4:0] pos_p1,
   output logic [4:0] pos_p2,
   output logic       turn,
   output logic [2:0] score_p1,
   output logic [2:0] score_p2,
   output logic       playing,
   output logic       game_over,
   output logic       winner
);

   localparam logic [2:0] LP_WIN_TAILS = 3'(WIN_TAILS);
   localparam logic [4:0] LP_LAST_TILE = 5'd23;
   localparam logic [4:0] LP_NUM_TILES = 5'd24;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_WIN  = 2'd2
   } state_t;

   state_t     r_state,    w_state_n;
   logic [4:0] r_pos_p1,   w_pos_p1_n;
   logic [4:0] r_pos_p2,   w_pos_p2_n;
   logic       r_turn,     w_turn_n;
   logic [2:0] r_score_p1, w_score_p1_n;
   logic [2:0] r_score_p2, w_score_p2_n;
   logic       r_winner,   w_winner_n;

   logic [4:0] w_out1;
   logic [4:0] w_out2;
   logic [4:0] w_pd_norm;
   logic [4:0] w_succ;
   logic       w_overtake;
   logic [2:0] w_act_score;
   logic [2:0] w_score_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_pos_p1   <= P1_START;
         r_pos_p2   <= P2_START;
         r_turn     <= 1'b0;
         r_score_p1 <= '0;
         r_score_p2 <= '0;
         r_winner   <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_pos_p1   <= w_pos_p1_n;
         r_pos_p2   <= w_pos_p2_n;
         r_turn     <= w_turn_n;
         r_score_p1 <= w_score_p1_n;
         r_score_p2 <= w_score_p2_n;
         r_winner   <= w_winner_n;
      end
   end

   always_comb begin
      w_out1      = r_turn ? r_pos_p2 : r_pos_p1;
      w_out2      = r_turn ? r_pos_p1 : r_pos_p2;
      // Downstream can return up to 31; fold 24..31 back onto the track.
      w_pd_norm   = (pos_data >= LP_NUM_TILES) ? (pos_data - LP_NUM_TILES) : pos_data;
      w_succ      = (w_out1 == LP_LAST_TILE) ? '0 : (w_out1 + 5'd1);
      w_overtake  = (w_out2 == w_succ);
      w_act_score = r_turn ? r_score_p2 : r_score_p1;
      w_score_inc = (w_act_score == 3'd7) ? 3'd7 : (w_act_score + 3'd1);
   end

   always_comb begin
      w_state_n    = r_state;
      w_pos_p1_n   = r_pos_p1;
      w_pos_p2_n   = r_pos_p2;
      w_turn_n     = r_turn;
      w_score_p1_n = r_score_p1;
      w_score_p2_n = r_score_p2;
      w_winner_n   = r_winner;

      if (start) begin
         w_state_n    = S_PLAY;
         w_pos_p1_n   = P1_START;
         w_pos_p2_n   = P2_START;
         w_turn_n     = 1'b0;
         w_score_p1_n = '0;
         w_score_p2_n = '0;
         w_winner_n   = 1'b0;
      end else begin
         unique case (r_state)
            S_PLAY: begin
               if (miss) begin
                  w_turn_n = ~r_turn;
               end else if (match) begin
                  if (r_turn) w_pos_p2_n = w_pd_norm;
                  else        w_pos_p1_n = w_pd_norm;
                  if (w_overtake) begin
                     if (r_turn) w_score_p2_n = w_score_inc;
                     else        w_score_p1_n = w_score_inc;
                     if (w_score_inc == LP_WIN_TAILS) begin
                        w_state_n  = S_WIN;
                        w_winner_n = r_turn;
                     end
                  end
               end
            end
            S_IDLE, S_WIN: begin
               w_state_n = r_state;
            end
            default: begin
               w_state_n = S_IDLE;
            end
         endcase
      end
   end

   assign out1      = w_out1;
   assign out2      = w_out2;
   assign pos_p1    = r_pos_p1;
   assign pos_p2    = r_pos_p2;
   assign turn      = r_turn;
   assign score_p1  = r_score_p1;
   assign score_p2  = r_score_p2;
   assign playing   = (r_state == S_PLAY);
   assign game_over = (r_state == S_WIN);
   assign winner    = r_winner;

endmodule

// File: tb/tb_chicken_turn_ctrl.sv
// Bench for chicken_turn_ctrl: directed scenarios plus randomized play checked
// against a tile/score model of the race rules.
module tb_chicken_turn_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       match = 1'b0;
   logic       miss = 1'b0;
   logic [4:0] pos_data = '0;
   logic [4:0] out1, out2, pos_p1, pos_p2;
   logic       turn, playing, game_over, winner;
   logic [2:0] score_p1, score_p2;

   int total = 0;
   int bad = 0;

   // Model: state 0 = idle, 1 = play, 2 = win
   int m_pos[2];
   int m_score[2];
   int m_turn, m_st, m_win;

   chicken_turn_ctrl #(
      .P1_START (5'd0),
      .P2_START (5'd12),
      .WIN_TAILS(3)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .match    (match),
      .miss     (miss),
      .pos_data (pos_data),
      .out1     (out1),
      .out2     (out2),
      .pos_p1   (pos_p1),
      .pos_p2   (pos_p2),
      .turn     (turn),
      .score_p1 (score_p1),
      .score_p2 (score_p2),
      .playing  (playing),
      .game_over(game_over),
      .winner   (winner)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_pos[0] = 0; m_pos[1] = 12;
      m_score[0] = 0; m_score[1] = 0;
      m_turn = 0; m_st = 0; m_win = 0;
   endfunction

   function automatic void model_apply(input bit s, input bit m, input bit x, input int pd);
      int a, o;
      bit ov;
      if (s) begin
         model_reset();
         m_st = 1;
      end else if (m_st == 1) begin
         if (x) begin
            m_turn = 1 - m_turn;
         end else if (m) begin
            a  = m_turn;
            o  = 1 - a;
            ov = (m_pos[o] == (m_pos[a] + 1) % 24);
            m_pos[a] = pd % 24;
            if (ov) begin
               m_score[a] = (m_score[a] + 1 > 7) ? 7 : m_score[a] + 1;
               if (m_score[a] == 3) begin
                  m_st  = 2;
                  m_win = a;
               end
            end
         end
      end
   endfunction

   function automatic logic [29:0] exp_vec();
      return {5'(m_pos[m_turn]), 5'(m_pos[1 - m_turn]), 5'(m_pos[0]), 5'(m_pos[1]),
              1'(m_turn), 3'(m_score[0]), 3'(m_score[1]),
              1'(m_st == 1), 1'(m_st == 2), 1'(m_win)};
   endfunction

   function automatic logic [29:0] obs_vec();
      return {out1, out2, pos_p1, pos_p2, turn, score_p1, score_p2, playing, game_over, winner};
   endfunction

   task automatic step(input bit s, input bit m, input bit x, input logic [4:0] pd);
      start = s; match = m; miss = x; pos_data = pd;
      @(posedge clk);
      model_apply(s, m, x, int'(pd));
      #1;
      start = 1'b0; match = 1'b0; miss = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      rst_n = 1'b0;
      #12;
      total++;
      if (obs_vec() !== exp_vec()) begin
         bad++;
         $display("FAIL reset_vec got=%h exp=%h", obs_vec(), exp_vec());
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 1, 1, 5'd9);
      total++;
      if (obs_vec() !== exp_vec()) begin
         bad++;
         $display("FAIL idle_ignore got=%h exp=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_start_move();
      step(1, 0, 0, 5'd0);
      total++;
      if ({pos_p1, pos_p2, turn, playing, out1, out2} !== {5'd0, 5'd12, 1'b0, 1'b1, 5'd0, 5'd12}) begin
         bad++;
         $display("FAIL start_init got p1=%0d p2=%0d t=%b pl=%b o1=%0d o2=%0d exp 0 12 0 1 0 12",
                  pos_p1, pos_p2, turn, playing, out1, out2);
      end
      step(0, 1, 0, 5'd1);
      total++;
      if (pos_p1 !== 5'd1 || turn !== 1'b0) begin
         bad++;
         $display("FAIL first_move got p1=%0d t=%b exp p1=1 t=0", pos_p1, turn);
      end
   endtask

   task automatic test_turn_handoff();
      step(0, 0, 1, 5'd0);
      total++;
      if ({turn, out1, out2} !== {1'b1, 5'd12, 5'd1}) begin
         bad++;
         $display("FAIL miss_handoff got t=%b o1=%0d o2=%0d exp 1 12 1", turn, out1, out2);
      end
      step(0, 1, 1, 5'd5);
      total++;
      if ({turn, pos_p1, pos_p2} !== {1'b0, 5'd1, 5'd12}) begin
         bad++;
         $display("FAIL miss_priority got t=%b p1=%0d p2=%0d exp 0 1 12", turn, pos_p1, pos_p2);
      end
   endtask

   task automatic test_overtake_wrap();
      step(1, 0, 0, 5'd0);
      step(0, 1, 0, 5'd23);
      step(0, 0, 1, 5'd0);
      step(0, 1, 0, 5'd0);
      step(0, 0, 1, 5'd0);
      total++;
      if ({pos_p1, pos_p2, turn, score_p1} !== {5'd23, 5'd0, 1'b0, 3'd0}) begin
         bad++;
         $display("FAIL wrap_setup got p1=%0d p2=%0d t=%b s1=%0d exp 23 0 0 0", pos_p1, pos_p2, turn, score_p1);
      end
      step(0, 1, 0, 5'd1);
      total++;
      if ({pos_p1, score_p1} !== {5'd1, 3'd1}) begin
         bad++;
         $display("FAIL overtake_wrap got p1=%0d s1=%0d exp 1 1", pos_p1, score_p1);
      end
   endtask

   task automatic test_wrap_norm();
      step(1, 0, 0, 5'd0);
      step(0, 1, 0, 5'd22);
      step(0, 0, 1, 5'd0);
      step(0, 1, 0, 5'd23);
      step(0, 0, 1, 5'd0);
      step(0, 1, 0, 5'd24);
      total++;
      if ({pos_p1, score_p1} !== {5'd0, 3'd1}) begin
         bad++;
         $display("FAIL norm24 got p1=%0d s1=%0d exp 0 1", pos_p1, score_p1);
      end
      step(0, 1, 0, 5'd25);
      total++;
      if ({pos_p1, score_p1} !== {5'd1, 3'd1}) begin
         bad++;
         $display("FAIL norm25 got p1=%0d s1=%0d exp 1 1", pos_p1, score_p1);
      end
   endtask

   task automatic test_win();
      step(1, 0, 0, 5'd0);
      step(0, 0, 1, 5'd0);
      step(0, 1, 0, 5'd23);
      for (int k = 0; k < 3; k++) begin
         step(0, 1, 0, 5'd1);
         total++;
         if ({pos_p2, score_p2} !== {5'd1, 3'(k + 1)}) begin
            bad++;
            $display("FAIL p2_overtake%0d got p2=%0d s2=%0d exp 1 %0d", k, pos_p2, score_p2, k + 1);
         end
         if (k < 2) step(0, 1, 0, 5'd23);
      end
      total++;
      if ({game_over, winner, playing} !== 3'b110) begin
         bad++;
         $display("FAIL win_flags got go=%b w=%b pl=%b exp 1 1 0", game_over, winner, playing);
      end
      step(0, 1, 0, 5'd23);
      total++;
      if ({pos_p2, score_p2, game_over} !== {5'd1, 3'd3, 1'b1}) begin
         bad++;
         $display("FAIL win_ignore got p2=%0d s2=%0d go=%b exp 1 3 1", pos_p2, score_p2, game_over);
      end
      step(1, 0, 0, 5'd0);
      total++;
      if (obs_vec() !== {5'd0, 5'd12, 5'd0, 5'd12, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL win_restart got=%h exp=%h", obs_vec(),
                  {5'd0, 5'd12, 5'd0, 5'd12, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0});
      end
   endtask

   task automatic test_async_reset();
      step(1, 0, 0, 5'd0);
      step(0, 1, 0, 5'd7);
      step(0, 0, 1, 5'd0);
      step(0, 1, 0, 5'd15);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (obs_vec() !== exp_vec()) begin
         bad++;
         $display("FAIL async_reset got=%h exp=%h", obs_vec(), exp_vec());
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 1, 0, 5'd3);
      total++;
      if (obs_vec() !== exp_vec()) begin
         bad++;
         $display("FAIL post_reset_idle got=%h exp=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      logic [4:0] pd;
      bit s, m, x;
      step(1, 0, 0, 5'd0);
      for (int i = 0; i < 600; i++) begin
         s = ($urandom_range(0, 79) == 0);
         m = ($urandom_range(0, 2) != 0);
         x = ($urandom_range(0, 4) == 0);
         // Bias towards landing just behind the opponent so overtakes happen often.
         if ($urandom_range(0, 1) == 1) pd = 5'((m_pos[1 - m_turn] + 23) % 24);
         else                          pd = 5'($urandom_range(0, 31));
         if (m_st == 2 && $urandom_range(0, 3) == 0) s = 1'b1;
         step(s, m, x, pd);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL random_cycle%0d got=%h exp=%h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_start_move();
      test_turn_handoff();
      test_overtake_wrap();
      test_wrap_norm();
      test_win();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
